// File: rtl/jtkunio_obj_pkg.sv
// Shared definitions for the Kunio object renderer.
//   obj_st_t   : draw FSM states
//   OBJ_PXLW   : width of a line-buffer entry, {pal[1:0], colour[3:0]}
//   LINE_W     : entries per line-buffer bank
//   unpack_pxl : extracts pixel i (0 = leftmost) from a planar 32-bit ROM word
package jtkunio_obj_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    DRAW,
    DONE
  } obj_st_t;

  localparam int unsigned OBJ_PXLW = 6;
  localparam int unsigned LINE_W   = 256;

  // Each byte of the word is one bit plane; bit 7-i of every plane forms pixel i.
  function automatic logic [3:0] unpack_pxl(input logic [31:0] d, input logic [2:0] i);
    logic [4:0] k;
    k = {2'b00, i};
    return {d[5'd31 - k], d[5'd23 - k], d[5'd15 - k], d[5'd7 - k]};
  endfunction

endpackage

// File: rtl/jtkunio_obj_linebuf.sv
// Double line buffer for object pixels.
//   clk, rst        : clock, asynchronous active-high reset
//   line_start      : toggles the bank select
//   wr_en/addr/data : draw port, always targets the current bank
//   pxl_cen, hdump, flip : playback port, reads the other bank
//   obj_pxl         : registered playback pixel, 0 when empty or hdump[8]=1
// Every playback read is followed one clk later by a clear of that entry,
// so a bank is blank again once it has been displayed.
module jtkunio_obj_linebuf
  import jtkunio_obj_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                line_start,
  input  logic                wr_en,
  input  logic [7:0]          wr_addr,
  input  logic [OBJ_PXLW-1:0] wr_data,
  input  logic                pxl_cen,
  input  logic [8:0]          hdump,
  input  logic                flip,
  output logic [OBJ_PXLW-1:0] obj_pxl
);

  logic                bank;
  logic                clr_we;
  logic                clr_bank;
  logic [7:0]          clr_addr;
  logic [7:0]          rd_addr;
  logic                wr_hit;
  logic [OBJ_PXLW-1:0] mem [2][LINE_W];

  always_comb begin
    rd_addr = flip ? ~hdump[7:0] : hdump[7:0];
    // A clear queued just before a bank swap could land on the location
    // being drawn; the fresh draw data must survive in that case.
    wr_hit  = wr_en && clr_we && (clr_bank == bank) && (clr_addr == wr_addr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank     <= 1'b0;
      clr_we   <= 1'b0;
      clr_bank <= 1'b0;
      clr_addr <= '0;
      obj_pxl  <= '0;
    end else begin
      if (line_start) bank <= ~bank;
      clr_we   <= pxl_cen && !hdump[8];
      clr_bank <= ~bank;
      clr_addr <= rd_addr;
      if (pxl_cen) obj_pxl <= hdump[8] ? '0 : mem[~bank][rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[bank][wr_addr] <= wr_data;
    if (clr_we && !wr_hit) mem[clr_bank][clr_addr] <= '0;
  end

endmodule

// File: rtl/jtkunio_obj_draw.sv
// Object pixel renderer: takes one sprite-row request, fetches the two
// 8-pixel ROM words, writes the opaque pixels into the draw bank and plays
// back the other bank as obj_pxl.
//   clk, rst, pxl_cen        : clock, async active-high reset, pixel enable
//   line_start               : line pulse, swaps banks and aborts a draw
//   hdump, flip              : playback column and screen mirror
//   draw, code, ysub, xpos, hflip, pal : draw request (taken when busy=0)
//   busy                     : request in progress
//   rom_addr, rom_cs, rom_ok, rom_data : object ROM port
//   obj_pxl                  : {pal, colour}, 0 = empty
module jtkunio_obj_draw
  import jtkunio_obj_pkg::*;
#(
  parameter logic [8:0] XOFFSET = 9'd0,
  parameter logic [3:0] TRANSP  = 4'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pxl_cen,
  input  logic                line_start,
  input  logic [8:0]          hdump,
  input  logic                flip,
  input  logic                draw,
  input  logic [12:0]         code,
  input  logic [3:0]          ysub,
  input  logic [8:0]          xpos,
  input  logic                hflip,
  input  logic [1:0]          pal,
  output logic                busy,
  output logic [17:0]         rom_addr,
  output logic                rom_cs,
  input  logic                rom_ok,
  input  logic [31:0]         rom_data,
  output logic [OBJ_PXLW-1:0] obj_pxl
);

  obj_st_t     st;
  logic [12:0] code_l;
  logic [3:0]  ysub_l;
  logic [8:0]  xpos_l;
  logic        hflip_l;
  logic [1:0]  pal_l;
  logic        half;
  logic [31:0] dat;
  logic [2:0]  cnt;

  logic        second;
  logic [2:0]  pix_i;
  logic [3:0]  colour;
  logic [8:0]  wr_x;
  logic        wr_en;

  always_comb begin
    // With hflip the first fetched word is half 1, so the draw order is
    // second-half-first; "second" tracks draw order, not ROM half.
    second = (half != hflip_l);
    pix_i  = hflip_l ? (3'd7 - cnt) : cnt;
    colour = unpack_pxl(dat, pix_i);
    wr_x   = xpos_l + XOFFSET + {5'd0, second, cnt};
    wr_en  = (st == DRAW) && !line_start && !wr_x[8] && (colour != TRANSP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      code_l   <= '0;
      ysub_l   <= '0;
      xpos_l   <= '0;
      hflip_l  <= 1'b0;
      pal_l    <= '0;
      half     <= 1'b0;
      dat      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
    end else if (line_start) begin
      st     <= IDLE;
      busy   <= 1'b0;
      rom_cs <= 1'b0;
    end else begin
      case (st)
        IDLE: if (draw) begin
          code_l   <= code;
          ysub_l   <= ysub;
          xpos_l   <= xpos;
          hflip_l  <= hflip;
          pal_l    <= pal;
          half     <= hflip;
          busy     <= 1'b1;
          rom_cs   <= 1'b1;
          rom_addr <= {code, hflip, ysub};
          st       <= FETCH;
        end
        // rom_ok here may still belong to the previous address
        FETCH: st <= WAIT;
        WAIT: if (rom_ok) begin
          dat <= rom_data;
          cnt <= '0;
          if (second) rom_cs <= 1'b0;
          st  <= DRAW;
        end
        DRAW: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (!second) begin
              half     <= ~half;
              rom_addr <= {code_l, ~half, ysub_l};
              st       <= FETCH;
            end else begin
              st <= DONE;
            end
          end
        end
        DONE: begin
          busy <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  jtkunio_obj_linebuf u_linebuf (
    .clk       (clk),
    .rst       (rst),
    .line_start(line_start),
    .wr_en     (wr_en),
    .wr_addr   (wr_x[7:0]),
    .wr_data   ({pal_l, colour}),
    .pxl_cen   (pxl_cen),
    .hdump     (hdump),
    .flip      (flip),
    .obj_pxl   (obj_pxl)
  );

endmodule

// File: tb/tb_jtkunio_obj_draw.sv
module tb_jtkunio_obj_draw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pxl_cen = 1'b0;
  logic        line_start = 1'b0;
  logic [8:0]  hdump = 9'h100;
  logic        flip = 1'b0;
  logic        draw = 1'b0;
  logic [12:0] code = '0;
  logic [3:0]  ysub = '0;
  logic [8:0]  xpos = '0;
  logic        hflip = 1'b0;
  logic [1:0]  pal = '0;
  logic        busy;
  logic [17:0] rom_addr;
  logic        rom_cs;
  logic        rom_ok = 1'b0;
  logic [31:0] rom_data = '0;
  logic [5:0]  obj_pxl;

  jtkunio_obj_draw #(.XOFFSET(9'd0), .TRANSP(4'd0)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .line_start(line_start),
    .hdump(hdump), .flip(flip), .draw(draw), .code(code), .ysub(ysub),
    .xpos(xpos), .hflip(hflip), .pal(pal), .busy(busy), .rom_addr(rom_addr),
    .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data), .obj_pxl(obj_pxl)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ROM model: words indexed by the half bit, per-half extra delay,
  // optional one-shot stale rom_ok during the first FETCH cycle.
  logic [31:0] rom_word [2];
  int          rom_dly  [2];
  bit          stale_pend = 0;

  initial begin
    bit          pcs = 0;
    logic [17:0] paddr = '0;
    int          cnt = 0;
    rom_word[0] = '0; rom_word[1] = '0;
    rom_dly[0] = 0;   rom_dly[1] = 0;
    forever begin
      @(negedge clk);
      if (!rom_cs) begin
        pcs = 0;
        rom_ok = 1'b0;
      end else if (!pcs || rom_addr != paddr) begin
        pcs = 1;
        paddr = rom_addr;
        cnt = 0;
        if (stale_pend) begin
          rom_ok = 1'b1;
          rom_data = 32'hFFFF_FFFF;
          stale_pend = 0;
        end else begin
          rom_ok = 1'b0;
        end
      end else begin
        cnt++;
        rom_ok = (cnt >= 1 + rom_dly[rom_addr[4]]);
        rom_data = rom_word[rom_addr[4]];
      end
    end
  end

  // Scoreboard queues
  logic [17:0] exp_addr [$];
  typedef struct {
    bit         care;
    logic [5:0] val;
    int         h;
  } pexp_t;
  pexp_t exp_pxl [$];

  // Address monitor: checks each new ROM request
  initial begin
    bit          pcs = 0;
    logic [17:0] paddr = '0;
    forever begin
      @(negedge clk);
      if (rom_cs && (!pcs || rom_addr != paddr)) begin
        if (exp_addr.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rom_addr unexpected request: got %h expected none", rom_addr);
        end else begin
          chk("rom_addr", 32'(rom_addr), 32'(exp_addr.pop_front()));
        end
      end
      pcs = rom_cs;
      paddr = rom_addr;
    end
  end

  // Pixel monitor: obj_pxl updates one clk after each pxl_cen
  initial forever begin
    @(posedge clk);
    if (pxl_cen) begin
      #1;
      if (exp_pxl.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL obj_pxl unexpected output: got %h expected none", obj_pxl);
      end else begin
        pexp_t e;
        e = exp_pxl.pop_front();
        if (e.care) chk($sformatf("obj_pxl h=%0d", e.h), 32'(obj_pxl), 32'(e.val));
      end
    end
  end

  // Reference image per bank, filled by hand after each draw
  logic [5:0] model [2][256];
  bit         tb_bank = 0;

  task automatic ls();
    @(posedge clk); #1;
    line_start = 1'b1;
    tb_bank = ~tb_bank;
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic play(input bit fl, input bit care);
    for (int h = 0; h <= 256; h++) begin
      pexp_t e;
      @(posedge clk); #1;
      hdump = 9'(h);
      flip = fl;
      pxl_cen = 1'b1;
      e.care = care;
      e.h = h;
      if (h >= 256) begin
        e.val = '0;
      end else begin
        int idx;
        idx = fl ? 255 - h : h;
        e.val = model[~tb_bank][idx];
        model[~tb_bank][idx] = '0;
      end
      exp_pxl.push_back(e);
    end
    @(posedge clk); #1;
    pxl_cen = 1'b0;
    hdump = 9'h100;
    flip = 1'b0;
  endtask

  task automatic issue(input logic [12:0] c, input logic [3:0] y, input logic [8:0] x,
                       input logic hf, input logic [1:0] p,
                       input logic [31:0] w0, input logic [31:0] w1);
    rom_word[0] = w0;
    rom_word[1] = w1;
    @(posedge clk); #1;
    code = c; ysub = y; xpos = x; hflip = hf; pal = p;
    draw = 1'b1;
    @(posedge clk); #1;
    draw = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp);
    int c = 1;
    while (busy && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk(name, 32'(c), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    n_checks++; n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 0);
    chk("reset rom_cs", 32'(rom_cs), 0);
    chk("reset rom_addr", 32'(rom_addr), 0);
    chk("reset obj_pxl", 32'(obj_pxl), 0);
    rst = 1'b0;

    // Flush undefined power-up contents of both banks
    ls(); play(1'b0, 1'b0);
    ls(); play(1'b0, 1'b0);

    // Basic draw
    exp_addr.push_back(18'h000A3);
    exp_addr.push_back(18'h000B3);
    issue(13'h0005, 4'd3, 9'd16, 1'b0, 2'd2, 32'h8000_0000, 32'h0);
    wait_done("latency basic", 22);
    model[tb_bank][16] = 6'h28;
    ls(); play(1'b0, 1'b1);

    // hflip: half 1 fetched first, bit 31 of half 0 lands at x=31
    exp_addr.push_back(18'h000B3);
    exp_addr.push_back(18'h000A3);
    issue(13'h0005, 4'd3, 9'd16, 1'b1, 2'd2, 32'h8000_0000, 32'h0);
    wait_done("latency hflip", 22);
    model[tb_bank][31] = 6'h28;
    ls(); play(1'b0, 1'b1);

    // Delayed rom_ok with a stale rom_ok during the first FETCH cycle
    rom_dly[0] = 10;
    stale_pend = 1;
    exp_addr.push_back(18'h24687);
    exp_addr.push_back(18'h24697);
    issue(13'h1234, 4'd7, 9'd40, 1'b0, 2'd1, 32'h0080_0000, 32'h0000_0001);
    wait_done("latency delayed", 32);
    rom_dly[0] = 0;
    model[tb_bank][40] = 6'h14;
    model[tb_bank][55] = 6'h11;
    ls(); play(1'b0, 1'b1);

    // Wrap and clip at the right edge
    exp_addr.push_back(18'h3FFEF);
    exp_addr.push_back(18'h3FFFF);
    issue(13'h1FFF, 4'hF, 9'd250, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("latency wrap", 22);
    for (int x = 250; x < 256; x++) model[tb_bank][x] = 6'h1F;
    ls(); play(1'b0, 1'b1);

    // Abort during the first half: pixels n=0..2 written before line_start
    exp_addr.push_back(18'h01400);
    issue(13'h00A0, 4'd0, 9'd100, 1'b0, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(posedge clk);
    #1;
    for (int x = 100; x < 103; x++) model[tb_bank][x] = 6'h3F;
    line_start = 1'b1;
    tb_bank = ~tb_bank;
    @(posedge clk); #1;
    line_start = 1'b0;
    chk("abort busy", 32'(busy), 0);
    chk("abort rom_cs", 32'(rom_cs), 0);
    play(1'b0, 1'b1);

    // Next request after an abort
    exp_addr.push_back(18'h00031);
    exp_addr.push_back(18'h00021);
    issue(13'h0001, 4'd1, 9'd200, 1'b1, 2'd2, 32'h8000_0000, 32'h0);
    wait_done("latency after abort", 22);
    model[tb_bank][215] = 6'h28;
    ls(); play(1'b0, 1'b1);

    // Flip playback and clear-on-read
    exp_addr.push_back(18'h00000);
    exp_addr.push_back(18'h00010);
    issue(13'h0000, 4'd0, 9'd0, 1'b0, 2'd2, 32'h8000_0000, 32'h0);
    wait_done("latency flip", 22);
    model[tb_bank][0] = 6'h28;
    ls(); play(1'b1, 1'b1);
    ls(); ls(); play(1'b0, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    chk("addr queue drained", 32'(exp_addr.size()), 0);
    chk("pixel queue drained", 32'(exp_pxl.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
